alu: RTL and testbench

- 8-bit adder/subtractor for the SAP-1 processor.
- Takes accumulator (ina) and B register (inb); drives the sum or difference onto the W bus when enabled.
- Adds a clocked status-flag register (C, Z, N, V) that captures the result whenever the ALU drives the bus, for later conditional-jump extensions.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_addsub.sv | 41 ++++
 rtl/alu.sv | 73 +++++++
 tb/tb_alu.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the SAP-1 ALU: data width, flag bit positions and
// operation encodings. Also holds the signed-overflow helper used by the
// adder/subtractor.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  // Bit positions inside the 4-bit flags vector {C,Z,N,V}
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  // Operation select carried on Su
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Signed overflow of a two's-complement add of a and b_eff (where b_eff is
  // already inverted for subtraction): the operands share a sign and the
  // sum's sign differs from them.
  function automatic logic calc_overflow(input logic a_msb,
                                         input logic b_eff_msb,
                                         input logic sum_msb);
    calc_overflow = (a_msb == b_eff_msb) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Pure combinational adder/subtractor. Subtraction is done as
// ina + ~inb + 1, so the carry out is the inverted borrow.
module alu_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             Su,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic [WIDTH-1:0] sum,
  output logic             c,
  output logic             z,
  output logic             n,
  output logic             v
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_raw;

  // Operand conditioning and the single shared adder
  always_comb begin
    w_b_eff = inb;
    if (Su == OP_SUB) begin
      w_b_eff = ~inb;
    end else begin
      w_b_eff = inb;
    end
    w_raw = {1'b0, ina} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, Su};
  end

  // Status derivation from the raw WIDTH+1 result
  always_comb begin
    sum = w_raw[WIDTH-1:0];
    c   = w_raw[WIDTH];
    z   = (w_raw[WIDTH-1:0] == {WIDTH{1'b0}});
    n   = w_raw[WIDTH-1];
    v   = calc_overflow(ina[WIDTH-1], w_b_eff[WIDTH-1], w_raw[WIDTH-1]);
  end

endmodule

// File: rtl/alu.sv
// SAP-1 ALU top: combinational add/subtract onto the W bus plus a status
// flag register {C,Z,N,V} that captures whenever the ALU drives the bus.
// Optional build macro ALU_TRISTATE_EN: when defined, result floats (all Z)
// while Eu=0 for a tri-state bus; otherwise result is driven to zero so it
// can be OR-combined with other bus sources.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             Su,
  input  logic             Eu,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH-1:0] w_sum;
  logic             w_c;
  logic             w_z;
  logic             w_n;
  logic             w_v;
  logic [3:0]       w_flags_nxt;
  logic [3:0]       r_flags;

  alu_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .Su  (Su),
    .ina (ina),
    .inb (inb),
    .sum (w_sum),
    .c   (w_c),
    .z   (w_z),
    .n   (w_n),
    .v   (w_v)
  );

  // Pack flags into their fixed positions; hold when the ALU is not on the bus
  always_comb begin
    w_flags_nxt = r_flags;
    if (Eu) begin
      w_flags_nxt[FLAG_C] = w_c;
      w_flags_nxt[FLAG_Z] = w_z;
      w_flags_nxt[FLAG_N] = w_n;
      w_flags_nxt[FLAG_V] = w_v;
    end else begin
      w_flags_nxt = r_flags;
    end
  end

  // Flag register, cleared asynchronously by clr_n
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_flags <= 4'b0000;
    end else begin
      r_flags <= w_flags_nxt;
    end
  end

  assign flags = r_flags;

  // Bus driver: result is combinational and ignores reset by design
`ifdef ALU_TRISTATE_EN
  assign result = Eu ? w_sum : {WIDTH{1'bz}};
`else
  assign result = Eu ? w_sum : {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the SAP-1 ALU: reset behaviour, a table of
// directed vectors, a mid-operation reset sequence and random vectors
// against an independent integer model. Expected flags go through a
// scoreboard queue and are compared after the capturing clock edge.
module tb_alu;

  logic       clk;
  logic       clr_n;
  logic       Su;
  logic       Eu;
  logic [7:0] ina;
  logic [7:0] inb;
  wire  [7:0] result;
  wire  [3:0] flags;

  int checks = 0;
  int errors = 0;

  logic [3:0] sb_q[$];

`ifdef ALU_TRISTATE_EN
  localparam logic [7:0] DIS_VAL = 8'hzz;
`else
  localparam logic [7:0] DIS_VAL = 8'h00;
`endif

  typedef struct {
    string      name;
    logic       su;
    logic       eu;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_r;
    logic [3:0] exp_f;
  } vec_t;

  vec_t vecs[10];

  alu dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .Su     (Su),
    .Eu     (Eu),
    .ina    (ina),
    .inb    (inb),
    .result (result),
    .flags  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_r(input string name, input logic [7:0] exp);
    checks++;
    if (result !== exp) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, result, exp);
    end
  endtask

  task automatic check_f(input string name, input logic [3:0] exp);
    checks++;
    if (flags !== exp) begin
      errors++;
      $display("FAIL %s flags: got %b expected %b", name, flags, exp);
    end
  endtask

  // Drive one vector, check the bus in the same cycle, then the flags
  task automatic apply(input string name, input logic su, input logic eu,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_r, input logic [3:0] exp_f);
    logic [3:0] f;
    @(negedge clk);
    Su = su; Eu = eu; ina = a; inb = b;
    #1;
    check_r(name, exp_r);
    sb_q.push_back(exp_f);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard: got empty queue expected one entry", name);
    end else begin
      f = sb_q.pop_front();
      check_f(name, f);
    end
  endtask

  initial begin
    logic [3:0] model_f;
    logic [3:0] prev_f;
    logic [7:0] model_r;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rsu;
    int         full;
    int         sres;

    vecs[0] = '{"add_05_03",   1'b0, 1'b1, 8'h05, 8'h03, 8'h08,   4'b0000};
    vecs[1] = '{"sub_borrow",  1'b1, 1'b1, 8'h03, 8'h05, 8'hFE,   4'b0010};
    vecs[2] = '{"add_ovf",     1'b0, 1'b1, 8'h7F, 8'h01, 8'h80,   4'b0011};
    vecs[3] = '{"dis_hold1",   1'b0, 1'b0, 8'h05, 8'h03, DIS_VAL, 4'b0011};
    vecs[4] = '{"add_wrap",    1'b0, 1'b1, 8'hFF, 8'h01, 8'h00,   4'b1100};
    vecs[5] = '{"sub_ovf",     1'b1, 1'b1, 8'h80, 8'h01, 8'h7F,   4'b1001};
    vecs[6] = '{"dis_hold2",   1'b1, 1'b0, 8'hFF, 8'h01, DIS_VAL, 4'b1001};
    vecs[7] = '{"add_neg_ovf", 1'b0, 1'b1, 8'h80, 8'h80, 8'h00,   4'b1101};
    vecs[8] = '{"sub_equal",   1'b1, 1'b1, 8'h42, 8'h42, 8'h00,   4'b1100};
    vecs[9] = '{"sub_05_03",   1'b1, 1'b1, 8'h05, 8'h03, 8'h02,   4'b1000};

    // Reset asserted with the ALU driving: flags clear, bus still live
    clr_n = 1'b0; Su = 1'b0; Eu = 1'b1; ina = 8'h05; inb = 8'h03;
    #1;
    check_f("reset_flags", 4'b0000);
    check_r("reset_result", 8'h08);
    @(posedge clk); #1;
    check_f("reset_hold_edge", 4'b0000);
    @(negedge clk);
    clr_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].name, vecs[i].su, vecs[i].eu, vecs[i].a, vecs[i].b,
            vecs[i].exp_r, vecs[i].exp_f);
    end

    // Asynchronous reset in the middle of a cycle, away from any edge
    @(negedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    check_f("midop_reset", 4'b0000);
    check_r("midop_result", 8'h02);
    @(negedge clk);
    clr_n = 1'b1;
    apply("post_reset", 1'b0, 1'b1, 8'h7F, 8'h01, 8'h80, 4'b0011);

    // Random vectors against an integer reference model
    prev_f = 4'b0011;
    for (int k = 0; k < 24; k++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rsu = 1'($urandom_range(0, 1));
      if (rsu) begin
        full       = int'(ra) - int'(rb);
        sres       = int'($signed(ra)) - int'($signed(rb));
        model_f[3] = (ra >= rb);
      end else begin
        full       = int'(ra) + int'(rb);
        sres       = int'($signed(ra)) + int'($signed(rb));
        model_f[3] = (full > 255);
      end
      model_r    = 8'(full);
      model_f[2] = (model_r == 8'h00);
      model_f[1] = model_r[7];
      model_f[0] = (sres > 127) || (sres < -128);
      if ((k % 6) == 5) begin
        apply("rand_dis", rsu, 1'b0, ra, rb, DIS_VAL, prev_f);
      end else begin
        apply("rand", rsu, 1'b1, ra, rb, model_r, model_f);
        prev_f = model_f;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000");
    $fatal(1);
  end

endmodule
